// File: rtl/tri_bit_serializer.sv
// Queues operand triples in a small FIFO and streams each one MSB first as
// three parallel bit slices, reloading back-to-back with no bubble.
module tri_bit_serializer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] c_in,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_a,
  output logic             ser_b,
  output logic             ser_c,
  output logic             ser_first,
  output logic             ser_last,
  output logic             busy,
  output logic [7:0]       word_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] MSB_IDX  = IDX_W'(WIDTH - 1);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e             state_q, state_d;
  logic [3*WIDTH-1:0] mem_q [DEPTH];
  logic [3*WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]     count_q, count_d;
  logic [WIDTH-1:0]   sa_q, sa_d, sb_q, sb_d, sc_q, sc_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [7:0]         word_count_q, word_count_d;

  logic fifo_empty, push, pop, ser_fire;

  assign fifo_empty = (count_q == '0);
  assign in_ready   = (count_q != FULL_CNT);
  assign push       = in_valid && in_ready;
  assign ser_valid  = (state_q == SHIFT);
  assign ser_fire   = ser_valid && ser_ready;
  // A pop happens either to start from IDLE or to chain straight into the
  // next triple on the final bit; both read the head in the same way.
  assign pop        = !fifo_empty &&
                      ((state_q == IDLE) || (ser_fire && idx_q == '0));

  assign ser_a      = ser_valid && sa_q[idx_q];
  assign ser_b      = ser_valid && sb_q[idx_q];
  assign ser_c      = ser_valid && sc_q[idx_q];
  assign ser_first  = ser_valid && (idx_q == MSB_IDX);
  assign ser_last   = ser_valid && (idx_q == '0);
  assign busy       = !fifo_empty || ser_valid;
  assign word_count = word_count_q;

  always_comb begin
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    state_d      = state_q;
    sa_d         = sa_q;
    sb_d         = sb_q;
    sc_d         = sc_q;
    idx_d        = idx_q;
    word_count_d = word_count_q;

    if (push) begin
      mem_d[wr_ptr_q] = {a_in, b_in, c_in};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (ser_fire) begin
      if (idx_q != '0) begin
        idx_d = idx_q - 1'b1;
      end else begin
        word_count_d = word_count_q + 8'd1;
        state_d      = IDLE;
      end
    end

    if (pop) begin
      {sa_d, sb_d, sc_d} = mem_q[rd_ptr_q];
      rd_ptr_d           = rd_ptr_q + 1'b1;
      idx_d              = MSB_IDX;
      state_d            = SHIFT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      sa_q         <= '0;
      sb_q         <= '0;
      sc_q         <= '0;
      idx_q        <= MSB_IDX;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      sa_q         <= sa_d;
      sb_q         <= sb_d;
      sc_q         <= sc_d;
      idx_q        <= idx_d;
      word_count_q <= word_count_d;
    end
  end

endmodule

// File: tb/tb_tri_bit_serializer.sv
// Scoreboard bench for tri_bit_serializer: accepted triples queue expected
// slices, a negedge monitor pops and compares every serial transfer.
module tb_tri_bit_serializer;

  localparam int WIDTH = 8;
  localparam int DEPTH = 2;

  logic             clk = 0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_in, b_in, c_in;
  logic             ser_valid, ser_ready;
  logic             ser_a, ser_b, ser_c, ser_first, ser_last, busy;
  logic [7:0]       word_count;

  tri_bit_serializer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .c_in(c_in),
    .ser_valid(ser_valid), .ser_ready(ser_ready),
    .ser_a(ser_a), .ser_b(ser_b), .ser_c(ser_c),
    .ser_first(ser_first), .ser_last(ser_last),
    .busy(busy), .word_count(word_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [4:0] sb [$];   // {a, b, c, first, last}
  logic [7:0] exp_wc = 8'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every transfer is compared against the oldest queued slice.
  always @(negedge clk) begin
    if (rst_n && ser_valid && ser_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_slice", 32'd1, 32'd0);
      end else begin
        logic [4:0] e;
        e = sb.pop_front();
        chk("slice", {27'd0, ser_a, ser_b, ser_c, ser_first, ser_last}, {27'd0, e});
      end
      if (ser_last) begin
        chk("word_count_before_last", {24'd0, word_count}, {24'd0, exp_wc});
        exp_wc = exp_wc + 8'd1;
      end
    end
  end

  task automatic queue_triple(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                              input logic [WIDTH-1:0] c);
    for (int k = WIDTH - 1; k >= 0; k--)
      sb.push_back({a[k], b[k], c[k], k == WIDTH - 1, k == 0});
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic push(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic [WIDTH-1:0] c);
    bit ok = 0;
    in_valid = 1; a_in = a; b_in = b; c_in = c;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    if (ok) begin
      queue_triple(a, b, c);
      @(posedge clk); #1;
    end else begin
      chk("push_timeout", 32'd1, 32'd0);
    end
    in_valid = 0;
  endtask

  task automatic wait_first();
    bit ok = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (ser_valid && ser_first) begin ok = 1; break; end
    end
    if (!ok) chk("first_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (!busy) begin ok = 1; break; end
    end
    if (!ok) chk("idle_timeout", 32'd1, 32'd0);
    chk("scoreboard_drained", sb.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    sb.delete();
    exp_wc = 8'd0;
    #1;
    chk("rst_ser_valid", {31'd0, ser_valid}, 32'd0);
    chk("rst_first_last", {30'd0, ser_first, ser_last}, 32'd0);
    chk("rst_abc", {29'd0, ser_a, ser_b, ser_c}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_word_count", {24'd0, word_count}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid = 0; a_in = '0; b_in = '0; c_in = '0; ser_ready = 0; rst_n = 1;
    @(posedge clk); #1;
    do_reset();

    // Single triple with latency check; scoreboard bits are 33/36/43 MSB first.
    ser_ready = 1;
    push(8'd33, 8'd36, 8'd43);
    @(negedge clk);
    chk("latency_E0_valid", {31'd0, ser_valid}, 32'd0);
    @(negedge clk);
    chk("latency_E1_valid_first", {30'd0, ser_valid, ser_first}, 32'd3);
    wait_idle();
    chk("single_word_count", {24'd0, word_count}, 32'd1);

    // Back-to-back: 16 contiguous valid cycles, second MSB slice is (1,0,1).
    push(8'd33, 8'd36, 8'd43);
    push(8'd255, 8'd0, 8'd128);
    begin
      int n = 0;
      wait_first();
      while (ser_valid && n < 40) begin
        n++;
        if (n == 9) chk("second_msb_slice", {28'd0, ser_a, ser_b, ser_c, ser_first}, 32'b1011);
        @(negedge clk);
      end
      chk("contiguous_valid", n, 32'd16);
    end
    wait_idle();
    chk("b2b_word_count", {24'd0, word_count}, 32'd3);

    // Backpressure on beat 4 for 3 cycles.
    push(8'd33, 8'd36, 8'd43);
    wait_first();
    repeat (3) begin @(posedge clk); #1; end
    ser_ready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_slice", {27'd0, ser_valid, ser_a, ser_b, ser_c, ser_last}, 32'b10000);
    end
    @(posedge clk); #1;
    ser_ready = 1;
    wait_idle();
    chk("bp_word_count", {24'd0, word_count}, 32'd4);

    // FIFO full with the shifter stalled: fourth triple waits for a pop.
    ser_ready = 0;
    push(8'd1, 8'd2, 8'd3);
    push(8'd4, 8'd5, 8'd6);
    push(8'd7, 8'd8, 8'd9);
    in_valid = 1; a_in = 8'd10; b_in = 8'd11; c_in = 8'd12;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(posedge clk); #1;
    ser_ready = 1;
    push(8'd10, 8'd11, 8'd12);
    wait_idle();
    chk("full_word_count", {24'd0, word_count}, 32'd8);

    // Reset at beat 5 with a second triple queued.
    push(8'd33, 8'd36, 8'd43);
    push(8'd200, 8'd100, 8'd50);
    wait_first();
    repeat (4) begin @(posedge clk); #1; end
    do_reset();
    push(8'd255, 8'd0, 8'd128);
    wait_first();
    chk("post_reset_msb", {29'd0, ser_a, ser_b, ser_c}, 32'b101);
    wait_idle();
    chk("post_reset_word_count", {24'd0, word_count}, 32'd1);

    // Wrap: 256 triples from a fresh reset.
    @(posedge clk); #1;
    do_reset();
    for (int i = 0; i < 256; i++)
      push(8'(i), 8'(~i), 8'(i * 3));
    wait_idle();
    chk("wrap_word_count", {24'd0, word_count}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
